rotary_input: RTL and testbench

ROTARY_INPUT -- requirements
Module: rotary_input

---
 rtl/rotary_input.sv | 202 ++++++++++++++++++++
 tb/tb_rotary_input.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rotary_input.sv
// Rotary encoder front end: synchronizes and debounces A/B (and optionally the push button),
// decodes quadrature into detent pulses. Define ROTARY_PRESS_EN to build the button path.
module rotary_input #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DETENT_STEPS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       btn_in,
  output logic [1:0] rotate_out,
  output logic       press_out
);

  // Channel indices into the per-input vectors.
  localparam int CH_A = 0;
  localparam int CH_B = 1;
`ifdef ROTARY_PRESS_EN
  localparam int CH_BTN = 2;
  localparam int NCH    = 3;
`else
  localparam int NCH    = 2;
`endif

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int ACC_W = $clog2(DETENT_STEPS) + 2;

  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    ROT_NONE = 2'b00,
    ROT_CW   = 2'b01,
    ROT_CCW  = 2'b10
  } rot_e;

  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam acc_t ACC_HI   = acc_t'(DETENT_STEPS - 1);
  localparam acc_t ACC_LO   = acc_t'(-(DETENT_STEPS - 1));

  // Raw pin vector; the button is only gathered when its path exists.
  logic [NCH-1:0] raw;
`ifdef ROTARY_PRESS_EN
  assign raw = {btn_in, b_in, a_in};
`else
  logic unused_btn;
  assign raw        = {b_in, a_in};
  assign unused_btn = btn_in;
`endif

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] sync1_d, sync1_q;
  logic [NCH-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncers: one stable bit and one saturating-free counter per channel
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] stable_d, stable_q;
  cnt_t           cnt_d [NCH];
  cnt_t           cnt_q [NCH];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        // The last counting cycle accepts the level instead of wrapping.
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is
  // cleared element by element in the reset branch like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quadrature decoder and detent accumulator
  // ---------------------------------------------------------------------------
  logic [1:0] ab_cur;
  logic [1:0] prev_ab_d, prev_ab_q;
  logic [1:0] pos_cur, pos_prev, pos_delta;
  logic       step_up, step_dn;
  acc_t       acc_d, acc_q;
  rot_e       rotate_d, rotate_q;

  // Position along the CW cycle 00,01,11,10 is {A, A^B}; a delta of +1/-1
  // (mod 4) is a legal step, a delta of 2 means both channels moved at once.
  function automatic logic [1:0] cycle_pos(input logic [1:0] ab);
    cycle_pos = {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    ab_cur    = {stable_q[CH_A], stable_q[CH_B]};
    prev_ab_d = ab_cur;
    pos_cur   = cycle_pos(ab_cur);
    pos_prev  = cycle_pos(prev_ab_q);
    pos_delta = pos_cur - pos_prev;
    step_up   = (pos_delta == 2'd1);
    step_dn   = (pos_delta == 2'd3);
  end

  always_comb begin
    acc_d    = acc_q;
    rotate_d = ROT_NONE;
    if (step_up) begin
      if (acc_q == ACC_HI) begin
        acc_d    = '0;
        rotate_d = ROT_CW;
      end else begin
        acc_d = acc_q + acc_t'(1);
      end
    end else if (step_dn) begin
      if (acc_q == ACC_LO) begin
        acc_d    = '0;
        rotate_d = ROT_CCW;
      end else begin
        acc_d = acc_q - acc_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab_q <= '0;
      acc_q     <= '0;
      rotate_q  <= ROT_NONE;
    end else begin
      prev_ab_q <= prev_ab_d;
      acc_q     <= acc_d;
      rotate_q  <= rotate_d;
    end
  end

  assign rotate_out = rotate_q;

  // ---------------------------------------------------------------------------
  // Push button edge detector
  // ---------------------------------------------------------------------------
`ifdef ROTARY_PRESS_EN
  logic btn_prev_d, btn_prev_q;
  logic press_d, press_q;

  always_comb begin
    btn_prev_d = stable_q[CH_BTN];
    press_d    = stable_q[CH_BTN] & ~btn_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      btn_prev_q <= btn_prev_d;
      press_q    <= press_d;
    end
  end

  assign press_out = press_q;
`else
  assign press_out = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_input.sv
// Scoreboard bench for rotary_input: stimulus predicts detent/press events into
// queues, a negedge monitor pops and compares them against the DUT outputs.
module tb_rotary_input;

  localparam int D     = 4;   // debounce cycles
  localparam int N     = 4;   // transitions per detent
  localparam int LAT   = 2 + D + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in, btn_in;
  logic [1:0] rotate_out;
  logic       press_out;

  rotary_input #(.DEBOUNCE_CYCLES(D), .DETENT_STEPS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .btn_in     (btn_in),
    .rotate_out (rotate_out),
    .press_out  (press_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the accepted encoder state at the event level.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [1:0] rot;
  } rot_ev_t;

  rot_ev_t    rq[$];
  int         pq[$];
  logic [1:0] m_ab  = 2'b00;   // {A,B}
  logic       m_btn = 1'b0;
  int         acc   = 0;

  // CW order 00 -> 01 -> 11 -> 10 -> 00, indexed by the {A,B} value.
  logic [1:0] cw_next  [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [1:0] ccw_next [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

  // A level driven right after edge k and held long enough is accepted and any
  // resulting pulse is visible after edge k+LAT.
  task automatic model_accept(input logic [1:0] ab, input logic btn, input int k);
    rot_ev_t ev;
`ifdef ROTARY_PRESS_EN
    if (btn && !m_btn) pq.push_back(k + LAT);
`endif
    m_btn = btn;
    if (ab != m_ab) begin
      if (cw_next[m_ab] == ab)       acc = acc + 1;
      else if (ccw_next[m_ab] == ab) acc = acc - 1;
      if (acc == N || acc == -N) begin
        ev.cyc = k + LAT;
        ev.rot = (acc == N) ? 2'b01 : 2'b10;
        rq.push_back(ev);
        acc = 0;
      end
      m_ab = ab;
    end
  endtask

  // Called just after a rising edge; drives a level and holds it h cycles.
  task automatic apply(input logic [1:0] ab, input logic btn, input int h);
    a_in   = ab[1];
    b_in   = ab[0];
    btn_in = btn;
    if (h >= D) model_accept(ab, btn, cyc);
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ab  = 2'b00;
    m_btn = 1'b0;
    acc   = 0;
    model_accept({a_in, b_in}, btn_in, cyc);
    repeat (D + 2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    rot_ev_t ev;
    int      pc;
    if (rst) begin
      check("reset_rotate", {30'd0, rotate_out}, 32'd0);
      check("reset_press", {31'd0, press_out}, 32'd0);
    end else begin
      if (rotate_out !== 2'b00) begin
        if (rq.size() == 0) begin
          check("rotate_spurious", {30'd0, rotate_out}, 32'd0);
        end else begin
          ev = rq.pop_front();
          check("rotate_dir", {30'd0, rotate_out}, {30'd0, ev.rot});
          check("rotate_cycle", cyc, ev.cyc);
        end
      end
      if (press_out !== 1'b0) begin
        if (pq.size() == 0) begin
          check("press_spurious", {31'd0, press_out}, 32'd0);
        end else begin
          pc = pq.pop_front();
          check("press_cycle", cyc, pc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] nxt;
    logic       nb;
    int         r;

    rst    = 1'b1;
    a_in   = 1'b0;
    b_in   = 1'b0;
    btn_in = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Full CW detent, then full CCW detent.
    apply(2'b01, 1'b0, 10); apply(2'b11, 1'b0, 10);
    apply(2'b10, 1'b0, 10); apply(2'b00, 1'b0, 10);
    apply(2'b10, 1'b0, 10); apply(2'b11, 1'b0, 10);
    apply(2'b01, 1'b0, 10); apply(2'b00, 1'b0, 10);

    // Short glitch on A only.
    apply(2'b10, 1'b0, 3);  apply(2'b00, 1'b0, 12);

    // Reversal: 2 CW, 2 CCW, 4 CW -> one CW pulse at the end.
    apply(2'b01, 1'b0, 10); apply(2'b11, 1'b0, 10);
    apply(2'b01, 1'b0, 10); apply(2'b00, 1'b0, 10);
    apply(2'b01, 1'b0, 10); apply(2'b11, 1'b0, 10);
    apply(2'b10, 1'b0, 10); apply(2'b00, 1'b0, 10);

    // Reset mid-detent after 3 CW steps, then one more CW step.
    apply(2'b01, 1'b0, 10); apply(2'b11, 1'b0, 10);
    apply(2'b10, 1'b0, 10);
    do_reset(2);
    apply(2'b00, 1'b0, 10);

    // Button held 20 cycles, then released.
    apply(2'b00, 1'b1, 20); apply(2'b00, 1'b0, 10);

    // Encoder resting at 11 across a reset: both channels move together.
    apply(2'b11, 1'b0, 10);
    do_reset(2);
    apply(2'b10, 1'b0, 10); apply(2'b00, 1'b0, 10);

    // Randomized mix of steps, glitches, invalid jumps, button and resets.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      nb = ($urandom_range(0, 3) == 0) ? ~m_btn : m_btn;
      if (r < 6) begin
        nxt = ($urandom_range(0, 2) != 0) ? cw_next[m_ab] : ccw_next[m_ab];
        apply(nxt, nb, $urandom_range(D, D + 6));
      end else if (r < 8) begin
        nxt = m_ab ^ 2'($urandom_range(1, 3));
        apply(nxt, ~m_btn, $urandom_range(1, D - 1));
        apply(m_ab, m_btn, $urandom_range(1, D + 4));
      end else if (r == 8) begin
        apply(m_ab ^ 2'b11, nb, $urandom_range(D, D + 6));
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset($urandom_range(1, 4));
      end else begin
        apply(m_ab, ~m_btn, $urandom_range(D, D + 6));
      end
    end

    repeat (20) @(posedge clk);
    #1;
    check("rotate_missed", rq.size(), 32'd0);
    check("press_missed", pq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
